// File: rtl/window_pkg.sv
// Shared definitions for the windowed register file: op encodings, FSM states and
// default window geometry.
package window_pkg;

  localparam int unsigned DefNWindows = 4;
  localparam int unsigned DefCwpW     = 2;

  typedef enum logic [1:0] {
    OP_SAVE    = 2'b00,
    OP_RESTORE = 2'b01,
    OP_TRAP    = 2'b10,
    OP_RETT    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCheck = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/register_window_ctrl_if.sv
// Request/response and direct-write bundle between the pipeline and the window controller.
interface register_window_ctrl_if
  import window_pkg::*;
#(
  parameter int unsigned NWINDOWS = DefNWindows,
  parameter int unsigned CWP_W    = DefCwpW
) ();

  logic                op_valid;
  op_e                 op;
  logic                op_ready;
  logic                cwp_we;
  logic [CWP_W-1:0]    cwp_in;
  logic                wim_we;
  logic [NWINDOWS-1:0] wim_in;
  logic [CWP_W-1:0]    cwp_out;
  logic [NWINDOWS-1:0] wim_out;
  logic [NWINDOWS-1:0] current_window;
  logic                done;
  logic                trap_overflow;
  logic                trap_underflow;

  modport master (
    output op_valid, op, cwp_we, cwp_in, wim_we, wim_in,
    input  op_ready, cwp_out, wim_out, current_window, done, trap_overflow, trap_underflow
  );

  modport slave (
    input  op_valid, op, cwp_we, cwp_in, wim_we, wim_in,
    output op_ready, cwp_out, wim_out, current_window, done, trap_overflow, trap_underflow
  );

endinterface

// File: rtl/window_decoder.sv
// Binary window pointer to one-hot window select.
module window_decoder #(
  parameter int unsigned NWINDOWS = 4,
  parameter int unsigned CWP_W    = 2
) (
  input  logic [CWP_W-1:0]    i_sel,
  output logic [NWINDOWS-1:0] o_onehot
);

  assign o_onehot = NWINDOWS'(1) << i_sel;

endmodule

// File: rtl/register_window_ctrl.sv
// Window pointer / invalid-mask controller: SAVE, RESTORE, TRAP and RETT moves with
// overflow/underflow detection, plus direct CWP/WIM writes while idle.
module register_window_ctrl
  import window_pkg::*;
#(
  parameter int unsigned NWINDOWS = DefNWindows,
  parameter int unsigned CWP_W    = DefCwpW
) (
  input logic                    Clk,
  input logic                    Clr,
  register_window_ctrl_if.slave  bus
);

  state_e              r_state, w_state_d;
  op_e                 r_op, w_op_d;
  logic [CWP_W-1:0]    r_cwp, w_cwp_d;
  logic [NWINDOWS-1:0] r_wim, w_wim_d;
  logic [NWINDOWS-1:0] r_cur_win, w_cur_win_d;
  logic                r_done, w_done_d;
  logic                r_ovf, w_ovf_d;
  logic                r_unf, w_unf_d;

  // Power-of-two window count, so plain CWP_W-bit arithmetic gives the modular wrap.
  logic [CWP_W-1:0] w_tgt_dec, w_tgt_inc;
  assign w_tgt_dec = r_cwp - CWP_W'(1);
  assign w_tgt_inc = r_cwp + CWP_W'(1);

  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_cwp_d   = r_cwp;
    w_wim_d   = r_wim;
    w_done_d  = 1'b0;
    w_ovf_d   = 1'b0;
    w_unf_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.cwp_we) w_cwp_d = bus.cwp_in;
        if (bus.wim_we) w_wim_d = bus.wim_in;
        if (bus.op_valid) begin
          w_op_d    = bus.op;
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        w_state_d = StDone;
        w_done_d  = 1'b1;
        unique case (r_op)
          OP_SAVE: begin
            if (r_wim[w_tgt_dec]) w_ovf_d = 1'b1;
            else                  w_cwp_d = w_tgt_dec;
          end
          OP_TRAP: w_cwp_d = w_tgt_dec;
          OP_RESTORE, OP_RETT: begin
            if (r_wim[w_tgt_inc]) w_unf_d = 1'b1;
            else                  w_cwp_d = w_tgt_inc;
          end
        endcase
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Decode the next CWP so the one-hot select is registered alongside CWP itself.
  window_decoder #(
    .NWINDOWS (NWINDOWS),
    .CWP_W    (CWP_W)
  ) u_decoder (
    .i_sel    (w_cwp_d),
    .o_onehot (w_cur_win_d)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state   <= StIdle;
      r_op      <= OP_SAVE;
      r_cwp     <= '0;
      r_wim     <= '0;
      r_cur_win <= NWINDOWS'(1);
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_op      <= w_op_d;
      r_cwp     <= w_cwp_d;
      r_wim     <= w_wim_d;
      r_cur_win <= w_cur_win_d;
      r_done    <= w_done_d;
      r_ovf     <= w_ovf_d;
      r_unf     <= w_unf_d;
    end
  end

  assign bus.op_ready       = (r_state == StIdle);
  assign bus.cwp_out        = r_cwp;
  assign bus.wim_out        = r_wim;
  assign bus.current_window = r_cur_win;
  assign bus.done           = r_done;
  assign bus.trap_overflow  = r_ovf;
  assign bus.trap_underflow = r_unf;

endmodule

// File: tb/tb_register_window_ctrl.sv
// Directed bench for register_window_ctrl with hand-computed expectations.
module tb_register_window_ctrl;
  import window_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  register_window_ctrl_if #(.NWINDOWS(4), .CWP_W(2)) bus ();

  register_window_ctrl #(
    .NWINDOWS (4),
    .CWP_W    (2)
  ) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_window(input logic [1:0] cwp, input logic [3:0] wim);
    bus.cwp_we = 1'b1;
    bus.cwp_in = cwp;
    bus.wim_we = 1'b1;
    bus.wim_in = wim;
    tick();
    bus.cwp_we = 1'b0;
    bus.wim_we = 1'b0;
    check("wr_cwp", bus.cwp_out, cwp);
    check("wr_wim", bus.wim_out, wim);
    check("wr_cw", bus.current_window, 4'b0001 << cwp);
  endtask

  // Any pending direct write set up by the caller lands at the accept edge.
  task automatic run_op(input string tag, input op_e o, input logic [1:0] exp_cwp,
                        input logic exp_ovf, input logic exp_unf);
    check({tag, "_rdy0"}, bus.op_ready, 1);
    bus.op_valid = 1'b1;
    bus.op       = o;
    tick();
    bus.op_valid = 1'b0;
    bus.cwp_we   = 1'b0;
    bus.wim_we   = 1'b0;
    check({tag, "_chk_rdy"}, bus.op_ready, 0);
    check({tag, "_chk_done"}, bus.done, 0);
    tick();
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_ovf"}, bus.trap_overflow, exp_ovf);
    check({tag, "_unf"}, bus.trap_underflow, exp_unf);
    check({tag, "_dn_rdy"}, bus.op_ready, 0);
    check({tag, "_cwp"}, bus.cwp_out, exp_cwp);
    check({tag, "_cw"}, bus.current_window, 4'b0001 << exp_cwp);
    tick();
    check({tag, "_done_end"}, bus.done, 0);
    check({tag, "_flags_end"}, {bus.trap_overflow, bus.trap_underflow}, 0);
    check({tag, "_rdy_end"}, bus.op_ready, 1);
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op       = OP_SAVE;
    bus.cwp_we   = 1'b0;
    bus.cwp_in   = '0;
    bus.wim_we   = 1'b0;
    bus.wim_in   = '0;

    tick();
    clr = 1'b0;
    check("rst_cwp", bus.cwp_out, 0);
    check("rst_wim", bus.wim_out, 0);
    check("rst_cw", bus.current_window, 4'b0001);
    check("rst_rdy", bus.op_ready, 1);
    check("rst_done", bus.done, 0);

    run_op("save_wrap", OP_SAVE, 2'd3, 1'b0, 1'b0);
    run_op("restore_wrap", OP_RESTORE, 2'd0, 1'b0, 1'b0);

    // Direct writes and SAVE in the same idle cycle: target window 2 is invalid.
    bus.cwp_we = 1'b1;
    bus.cwp_in = 2'd3;
    bus.wim_we = 1'b1;
    bus.wim_in = 4'b0100;
    run_op("ovf", OP_SAVE, 2'd3, 1'b1, 1'b0);
    check("ovf_wim", bus.wim_out, 4'b0100);

    set_window(2'd3, 4'b0001);
    run_op("unf_restore", OP_RESTORE, 2'd3, 1'b0, 1'b1);
    run_op("unf_rett", OP_RETT, 2'd3, 1'b0, 1'b1);

    set_window(2'd0, 4'b1000);
    run_op("trap", OP_TRAP, 2'd3, 1'b0, 1'b0);

    set_window(2'd3, 4'b0000);
    run_op("rett_ok", OP_RETT, 2'd0, 1'b0, 1'b0);

    // Back-to-back SAVEs with op_valid held; a CWP write during CHECK must be ignored.
    set_window(2'd3, 4'b0000);
    bus.op       = OP_SAVE;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_cwp;
      exp_cwp = 2'(2 - i);
      tick();
      check("b2b_chk_done", bus.done, 0);
      bus.cwp_we = 1'b1;
      bus.cwp_in = 2'd1;
      tick();
      bus.cwp_we = 1'b0;
      check("b2b_done", bus.done, 1);
      check("b2b_cwp", bus.cwp_out, exp_cwp);
      check("b2b_ovf", bus.trap_overflow, 0);
      tick();
      check("b2b_idle_done", bus.done, 0);
      check("b2b_idle_rdy", bus.op_ready, 1);
    end
    bus.op_valid = 1'b0;
    tick();
    check("b2b_final_cwp", bus.cwp_out, 3);

    // Reset during CHECK discards the in-flight SAVE.
    set_window(2'd2, 4'b0000);
    bus.op       = OP_SAVE;
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    check("mid_rdy", bus.op_ready, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("mid_done", bus.done, 0);
    check("mid_ovf", bus.trap_overflow, 0);
    check("mid_cwp", bus.cwp_out, 0);
    check("mid_cw", bus.current_window, 4'b0001);
    check("mid_rdy_after", bus.op_ready, 1);
    tick();
    check("mid_done_later", bus.done, 0);
    check("mid_cwp_later", bus.cwp_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_window_ctrl.md
# register_window_ctrl

Window-management stage sitting directly upstream of the windowed register file. Holds the current window pointer (CWP) and window invalid mask (WIM). Executes SAVE, RESTORE, trap-entry and RETT window moves, detecting window overflow/underflow. Drives the register file's one-hot `current_window` select.

## Interface
- `NWINDOWS`, default 4: number of register windows; a power of two, 2..32.
- `CWP_W`, default 2: log2(NWINDOWS).
- `Clk` in 1: clock, rising edge.
- `Clr` in 1: reset; synchronous, active-high.
- `op_valid` in 1: window operation request.
- `op` in 2: 00 SAVE, 01 RESTORE, 10 TRAP (trap entry), 11 RETT.
- `op_ready` out 1: block can accept an operation; high only in IDLE.
- `cwp_we` in 1: direct CWP write (WRPSR path).
- `cwp_in` in CWP_W: CWP write data.
- `wim_we` in 1: direct WIM write (WRWIM path).
- `wim_in` in NWINDOWS: WIM write data.
- `cwp_out` out CWP_W: current window pointer.
- `wim_out` out NWINDOWS: current window invalid mask.
- `current_window` out NWINDOWS: one-hot window select to the register file; bit n set ⇔ CWP = n.
- `done` out 1: one-cycle pulse when an operation completes, with or without a trap.
- `trap_overflow` out 1: one-cycle pulse with `done`; SAVE target window is invalid.
- `trap_underflow` out 1: one-cycle pulse with `done`; RESTORE/RETT target window is invalid.

## Operation
- FSM states: IDLE, CHECK, DONE.
- IDLE:
  - `op_ready`=1.
  - `op_valid` high → latch `op`, go to CHECK.
- CHECK:
  - Compute target window: SAVE/TRAP use (CWP−1) mod NWINDOWS; RESTORE/RETT use (CWP+1) mod NWINDOWS.
  - Register the target and `WIM[target]`, then go to DONE.
- Commit at the edge from CHECK to DONE:
  - SAVE with `WIM[target]`=1 → CWP unchanged, `trap_overflow`=1.
  - RESTORE/RETT with `WIM[target]`=1 → CWP unchanged, `trap_underflow`=1.
  - TRAP: never checks WIM; CWP always moves to the target.
  - Any other case: CWP ← target.
- DONE:
  - `done`=1 for exactly one cycle, trap flags valid alongside it.
  - Go to IDLE.
- Wrap-around: CWP 0 −1 → NWINDOWS−1; CWP NWINDOWS−1 +1 → 0.
- Direct writes:
  - `cwp_we`/`wim_we` are honoured only in IDLE and ignored in CHECK and DONE.
  - `wim_in` bits ≥ NWINDOWS are masked to 0.
  - Write and op accepted in the same IDLE cycle: the write lands at that edge, and CHECK evaluates using the new CWP/WIM values.
- Ops arriving in CHECK or DONE are not accepted; the requester must hold `op_valid` until it sees `op_ready` at a sampling edge.
- Reset values, applied at the first rising edge with `Clr`=1:
  - State IDLE, CWP=0, WIM=0, `current_window`=0…01.
  - `done`/trap flags 0; `op_ready`=1 once `Clr` falls.
  - `Clr` has priority over everything. Asserting it in CHECK or DONE discards the in-flight op: no `done` and no trap pulse after reset.

## Timing
- Op accepted at edge k → CHECK during cycle k+1 → `done`/trap flags high during cycle k+2.
- `cwp_out`/`current_window` hold the new value from edge k+2.
- `op_ready` is low during cycles k+1 and k+2 and high again from edge k+3.
- Maximum throughput: one operation per 3 cycles.
- `current_window` is registered in lockstep with CWP; there is no combinational path from `op` to `current_window`.
- Direct write in IDLE at edge k: `cwp_out`/`wim_out`/`current_window` are updated from edge k.
- All outputs are glitch-free registered signals except `op_ready`, which decodes state only.

## Structure
- Shared package `window_pkg`:
  - `op` encodings: OP_SAVE, OP_RESTORE, OP_TRAP, OP_RETT.
  - FSM state encoding.
  - Default NWINDOWS and CWP_W, reused by the register file and its bench.
- Sub-module `window_decoder`: CWP_W → NWINDOWS binary-to-one-hot decoder driving `current_window`; also reusable in the register file bench.

## Test plan
- Reset: `Clr`=1 for one edge → `cwp_out`=0, `wim_out`=0000, `current_window`=0001, `op_ready`=1, `done`=0.
- SAVE wrap: WIM=0000, CWP=0, SAVE → `done` at k+2, no trap, `cwp_out`=3, `current_window`=1000. RESTORE then → `cwp_out`=0, `current_window`=0001.
- Overflow: `wim_we` with 0100 and `cwp_we` with 3 in IDLE, plus SAVE in the same cycle → `trap_overflow`=1 with `done`, `cwp_out` stays 3, `current_window` stays 1000.
- Underflow and TRAP:
  - WIM=0001, CWP=3, RESTORE → `trap_underflow`=1, CWP stays 3.
  - WIM=1000, CWP=0, TRAP → `cwp_out`=3, no trap flag.
- Back-to-back: `op_valid` held high with SAVE from CWP=3, WIM=0 → `done` pulses every 3 cycles, CWP steps 2,1,0,3. `cwp_we` during CHECK is ignored.
- Reset mid-op: SAVE accepted, `Clr`=1 during CHECK → no `done`, `cwp_out`=0, `current_window`=0001, `op_ready`=1 after `Clr` falls.
